// File: rtl/serial_compare_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
// Combinational only; no latency and no backpressure of its own.
package serial_compare_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } cmp_state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

  function automatic int chunk_count(input int n, input int k);
    return n / k;
  endfunction

  // A single-chunk compare still needs a 1-bit counter.
  function automatic int cnt_width(input int n, input int k);
    return (n / k > 1) ? $clog2(n / k) : 1;
  endfunction

endpackage

// File: rtl/serial_compare_chunk.sv
// Unsigned K-bit compare of one chunk into a one-hot cmp_result_t.
// Purely combinational: zero latency, no backpressure.
module serial_compare_chunk
  import serial_compare_pkg::*;
#(
  parameter int K = 1
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output cmp_result_t  res
);

  always_comb begin
    res    = '0;
    res.eq = (a == b);
    res.lt = (a < b);
    res.gt = (a > b);
  end

endmodule

// File: rtl/serial_logical_compare.sv
// Serial N-bit unsigned compare, K bits/cycle MSB first; one-hot eq/lt/gt held until out_ready.
// Latency N/K edges (or first differing chunk + 1 with SERIAL_COMPARE_EARLY_EXIT_EN); accepts only in IDLE.
module serial_logical_compare
  import serial_compare_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         eq,
  output logic         lt,
  output logic         gt,
  output logic         busy
);

  localparam int CHUNKS = chunk_count(N, K);
  localparam int CW     = cnt_width(N, K);

  if (K < 1 || K > N || (N % K) != 0) begin : g_bad_params
    $error("serial_logical_compare: K must be in 1..N and divide N");
  end

  cmp_state_t    state, state_nxt;
  logic [N-1:0]  sa, sb;
  logic [CW-1:0] cnt;
  logic          decided;
  cmp_result_t   dec, res, cur, fin;
  logic          last;

  serial_compare_chunk #(.K(K)) u_chunk (
    .a   (sa[N-1 -: K]),
    .b   (sb[N-1 -: K]),
    .res (cur)
  );

  assign last = (cnt == CW'(CHUNKS - 1));
  // A latched decision wins; otherwise the current chunk decides (eq if it matches too).
  assign fin  = decided ? dec : cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = SHIFT;
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
      SHIFT: if (last || (!decided && !cur.eq)) state_nxt = DONE;
`else
      SHIFT: if (last) state_nxt = DONE;
`endif
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      dec     <= '0;
      res     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa      <= a;
          sb      <= b;
          cnt     <= '0;
          decided <= 1'b0;
          dec     <= '0;
        end
        SHIFT: begin
          sa  <= sa << K;
          sb  <= sb << K;
          cnt <= cnt + CW'(1);
          if (!decided && !cur.eq) begin
            decided <= 1'b1;
            dec     <= cur;
          end
          if (state_nxt == DONE) res <= fin;
        end
        DONE: if (out_ready) res <= '0;
        default: res <= '0;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);
  assign eq        = res.eq;
  assign lt        = res.lt;
  assign gt        = res.gt;

endmodule

// File: tb/tb_serial_logical_compare.sv
// Bench for serial_logical_compare: K=1 and K=4 instances checked against a ==/< reference model.
module tb_serial_logical_compare;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv   [2];
  logic       ir   [2];
  logic [7:0] av   [2];
  logic [7:0] bv   [2];
  logic       ov   [2];
  logic       ordy [2];
  logic       eqo  [2];
  logic       lto  [2];
  logic       gto  [2];
  logic       bsy  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_logical_compare #(.N(8), .K(1)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .eq(eqo[0]), .lt(lto[0]), .gt(gto[0]), .busy(bsy[0])
  );

  serial_logical_compare #(.N(8), .K(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .eq(eqo[1]), .lt(lto[1]), .gt(gto[1]), .busy(bsy[1])
  );

  // Expected {eq,lt,gt} straight from unsigned arithmetic.
  function automatic logic [2:0] ref_res(input logic [7:0] x, input logic [7:0] y);
    return {x == y, x < y, x > y};
  endfunction

  // Edges from accept to out_valid.
  function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y, input int k);
    int chunks;
    chunks = 8 / k;
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    for (int i = 0; i < chunks; i++) begin
      int cx, cy, mask;
      mask = (1 << k) - 1;
      cx = (int'(x) >> (8 - (i + 1) * k)) & mask;
      cy = (int'(y) >> (8 - (i + 1) * k)) & mask;
      if (cx != cy) return i + 1;
    end
`endif
    return chunks;
  endfunction

  function automatic logic [2:0] obs(input int d);
    return {eqo[d], lto[d], gto[d]};
  endfunction

  // Offer one pair to instance d, return observed latency and result at the first out_valid.
  task automatic drive_pair(input int d, input logic [7:0] x, input logic [7:0] y,
                            output int lat, output logic [2:0] r, output bit ok);
    int t;
    ok = 1'b0; lat = 0; r = '0; t = 0;
    @(negedge clk);
    while (!ir[d] && t < 100) begin @(negedge clk); t++; end
    if (!ir[d]) return;
    iv[d] = 1'b1; av[d] = x; bv[d] = y;
    @(posedge clk);
    @(negedge clk);
    iv[d] = 1'b0;
    for (t = 0; t < 100; t++) begin
      if (t > 0) @(negedge clk);
      if (ov[d]) begin ok = 1'b1; lat = t; r = obs(d); return; end
    end
  endtask

  task automatic test_reset;
    bit seen;
    #1;
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || obs(0) !== 3'b000 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ir=%b ov=%b res=%b busy=%b, required 1 0 000 0", ir[0], ov[0], obs(0), bsy[0]);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 8'hA5; bv[0] = 8'hA4;
    @(posedge clk);
    @(negedge clk) iv[0] = 1'b0;
    checks++;
    if (bsy[0] !== 1'b1) begin
      errors++; $display("FAIL busy_in_shift: busy=%b, required 1", bsy[0]);
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || obs(0) !== 3'b000 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ir=%b ov=%b res=%b busy=%b, required 1 0 000 0", ir[0], ov[0], obs(0), bsy[0]);
    end
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || ir[0] !== 1'b1) begin
      errors++; $display("FAIL reset_abort: out_valid_seen=%b ir=%b, required 0 1", seen, ir[0]);
    end
  endtask

  task automatic test_equal;
    int lat; logic [2:0] r; bit ok;
    ordy[0] = 1'b1;
    drive_pair(0, 8'h3C, 8'h3C, lat, r, ok);
    checks++;
    if (!ok || lat != ref_lat(8'h3C, 8'h3C, 1) || r !== ref_res(8'h3C, 8'h3C)) begin
      errors++; $display("FAIL equal: ok=%b lat=%0d res=%b, required lat=%0d res=100", ok, lat, r, ref_lat(8'h3C, 8'h3C, 1));
    end
    checks++;
    if (ir[0] !== 1'b0) begin errors++; $display("FAIL equal_ready_in_done: ir=%b, required 0", ir[0]); end
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || obs(0) !== 3'b000) begin
      errors++; $display("FAIL equal_after_handshake: ir=%b ov=%b res=%b, required 1 0 000", ir[0], ov[0], obs(0));
    end
  endtask

  task automatic test_msb;
    int lat; logic [2:0] r; bit ok;
    drive_pair(0, 8'h80, 8'h7F, lat, r, ok);
    checks++;
    if (!ok || lat != ref_lat(8'h80, 8'h7F, 1) || r !== 3'b001) begin
      errors++; $display("FAIL msb_diff: ok=%b lat=%0d res=%b, required lat=%0d res=001", ok, lat, r, ref_lat(8'h80, 8'h7F, 1));
    end
  endtask

  task automatic test_lsb_k4;
    int lat; logic [2:0] r; bit ok;
    drive_pair(1, 8'h12, 8'h13, lat, r, ok);
    checks++;
    if (!ok || lat != 2 || r !== 3'b010) begin
      errors++; $display("FAIL lsb_diff_k4: ok=%b lat=%0d res=%b, required lat=2 res=010", ok, lat, r);
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [2:0] r; bit ok; logic [7:0] x, y;
    x = 8'($urandom); y = x ^ 8'h10;
    ordy[0] = 1'b0;
    drive_pair(0, x, y, lat, r, ok);
    checks++;
    if (!ok || r !== ref_res(x, y)) begin
      errors++; $display("FAIL bp_result: ok=%b res=%b, required %b", ok, r, ref_res(x, y));
    end
    iv[0] = 1'b1; av[0] = ~x; bv[0] = x;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || obs(0) !== ref_res(x, y)) begin
        errors++; $display("FAIL bp_hold: ov=%b ir=%b res=%b, required 1 0 %b", ov[0], ir[0], obs(0), ref_res(x, y));
      end
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
      errors++; $display("FAIL bp_release: ir=%b ov=%b, required 1 0", ir[0], ov[0]);
    end
    iv[0] = 1'b0;
  endtask

  task automatic test_random;
    int lat; logic [2:0] r; bit ok; logic [7:0] x, y; int d, k;
    for (int i = 0; i < 16; i++) begin
      d = i % 2; k = (d == 0) ? 1 : 4;
      x = 8'($urandom);
      case ($urandom_range(0, 2))
        0: y = x;
        1: y = x ^ (8'h01 << $urandom_range(0, 7));
        default: y = 8'($urandom);
      endcase
      ordy[d] = 1'b1;
      drive_pair(d, x, y, lat, r, ok);
      checks++;
      if (!ok || lat != ref_lat(x, y, k) || r !== ref_res(x, y)) begin
        errors++;
        $display("FAIL random k=%0d a=%h b=%h: ok=%b lat=%0d res=%b, required lat=%0d res=%b",
                 k, x, y, ok, lat, r, ref_lat(x, y, k), ref_res(x, y));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pa[$], pb[$];
    logic [2:0] exp_q[$];
    logic [2:0] e;
    int n, got, cyc;
    pa = '{8'h00, 8'hFF, 8'h55}; pb = '{8'hFF, 8'h00, 8'h55};
    for (int i = 0; i < 8; i++) begin pa.push_back(8'($urandom)); pb.push_back(8'($urandom)); end
    n = pa.size();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int t;
          t = 0;
          @(negedge clk);
          iv[0] = 1'b0;
          while (!ir[0] && t < 200) begin @(negedge clk); t++; end
          if (ir[0]) begin
            iv[0] = 1'b1; av[0] = pa[i]; bv[0] = pb[i];
            exp_q.push_back(ref_res(pa[i], pb[i]));
            @(posedge clk);
          end
        end
        @(negedge clk) iv[0] = 1'b0;
      end
      begin
        got = 0; cyc = 0;
        while (got < n && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          ordy[0] = 1'($urandom_range(0, 1));
          if (ov[0] && ordy[0]) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL b2b_unexpected: res=%b with no pair outstanding", obs(0));
            end else begin
              e = exp_q.pop_front();
              if (obs(0) !== e) begin
                errors++; $display("FAIL b2b_result #%0d: res=%b, required %b", got, obs(0), e);
              end
            end
          end
        end
        ordy[0] = 1'b1;
      end
    join
    checks++;
    if (got != n) begin
      errors++; $display("FAIL b2b_timeout: got %0d results, required %0d", got, n);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; av[d] = '0; bv[d] = '0; ordy[d] = 1'b1;
    end
    test_reset();
    test_equal();
    test_msb();
    test_lsb_k4();
    test_backpressure();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
